// File: rtl/mux_scan_capture.sv
// mux_scan_capture: sequential reader for an external 8-to-1 mux (74HC151 style).
// It walks the select lines through every channel and waits SETTLE cycles on each
// channel before sampling Y/YF. The samples are collected in shadow registers.
// data_out/err_out are published together with a one-cycle done pulse, and only
// once the whole scan has completed.
module mux_scan_capture #(
    parameter int SEL_W  = 3,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mux_y,
    input  logic                  mux_yf,
    output logic [SEL_W-1:0]      mux_sel,
    output logic                  mux_en_n,
    output logic [(2**SEL_W)-1:0] data_out,
    output logic [(2**SEL_W)-1:0] err_out,
    output logic                  busy,
    output logic                  done
);

    localparam int CH = 2 ** SEL_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // The counter tops out at SETTLE-1, so 4 bits cover the legal range 1..15.
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] SEL_ONE     = {{(SEL_W-1){1'b0}}, 1'b1};

    // The complementary outputs disagree with the expected YF == ~Y relation.
    function automatic logic chan_err(input logic y, input logic yf);
        return (yf == y);
    endfunction

    logic [1:0]       state_q,  state_d;
    logic [SEL_W-1:0] ch_q,     ch_d;
    logic [3:0]       cnt_q,    cnt_d;
    logic [CH-1:0]    shd_q,    shd_d;
    logic [CH-1:0]    she_q,    she_d;
    logic [CH-1:0]    data_q,   data_d;
    logic [CH-1:0]    err_q,    err_d;
    logic             en_n_q,   en_n_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Next-state logic: the scan sequencer, the shadow capture and the result publish.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        shd_d   = shd_q;
        she_d   = she_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    ch_d    = '0;
                    cnt_d   = 4'd0;
                    shd_d   = '0;
                    she_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                shd_d[ch_q] = mux_y;
                she_d[ch_q] = chan_err(mux_y, mux_yf);
                if (ch_q == SEL_LAST) begin
                    // Publish the complete word, including this last sample.
                    state_d = ST_DONE;
                    ch_d    = '0;
                    data_d  = shd_d;
                    err_d   = she_d;
                end else begin
                    state_d = ST_WAIT;
                    ch_d    = ch_q + SEL_ONE;
                    cnt_d   = 4'd0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = '0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // The outputs are registered from the next state, so they change on the same edge as the state.
    always_comb begin
        en_n_d = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        if ((state_d == ST_WAIT) || (state_d == ST_SAMPLE)) begin
            en_n_d = 1'b0;
            busy_d = 1'b1;
        end else begin
            done_d = (state_d == ST_DONE);
        end
    end

    // State and output registers; reset aborts any scan in flight at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            cnt_q   <= 4'd0;
            shd_q   <= '0;
            she_q   <= '0;
            data_q  <= '0;
            err_q   <= '0;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            shd_q   <= shd_d;
            she_q   <= she_d;
            data_q  <= data_d;
            err_q   <= err_d;
            en_n_q  <= en_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mux_sel  = ch_q;
    assign mux_en_n = en_n_q;
    assign data_out = data_q;
    assign err_out  = err_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
